// File: rtl/sevenseg_pkg.sv
// Shared 7-segment code table {a,b,c,d,e,f,g}, active-high, used by both the
// hex-to-segment encoder and the segment-to-hex decoder.
package sevenseg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A_HEX = 7'b1110111;
  localparam logic [6:0] SEG_B_HEX = 7'b0011111;
  localparam logic [6:0] SEG_C_HEX = 7'b1001110;
  localparam logic [6:0] SEG_D_HEX = 7'b0111101;
  localparam logic [6:0] SEG_E_HEX = 7'b1001111;
  localparam logic [6:0] SEG_F_HEX = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic       err;
    logic [3:0] hex;
  } seg_dec_t;

  // Encoder direction, kept here so both directions read the same constants.
  function automatic logic [6:0] seg_encode(input logic [3:0] hex);
    case (hex)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A_HEX;
      4'hB: return SEG_B_HEX;
      4'hC: return SEG_C_HEX;
      4'hD: return SEG_D_HEX;
      4'hE: return SEG_E_HEX;
      default: return SEG_F_HEX;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_decoder_if.sv
// Decoded-digit output channel: valid/ready handshake plus the overrun pulse.
interface sevenseg_decoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_hex;
  logic       out_err;
  logic       overrun;

  modport master (output out_valid, output out_hex, output out_err, output overrun,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_hex, input  out_err, input  overrun,
                  output out_ready);
endinterface

// File: rtl/sevenseg_lut.sv
// Combinational segment-pattern to {err, hex} lookup; unknown patterns give err=1, hex=0.
module sevenseg_lut
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  always_comb begin
    dec = '{err: 1'b0, hex: 4'h0};
    case (seg)
      SEG_0:     dec.hex = 4'h0;
      SEG_1:     dec.hex = 4'h1;
      SEG_2:     dec.hex = 4'h2;
      SEG_3:     dec.hex = 4'h3;
      SEG_4:     dec.hex = 4'h4;
      SEG_5:     dec.hex = 4'h5;
      SEG_6:     dec.hex = 4'h6;
      SEG_7:     dec.hex = 4'h7;
      SEG_8:     dec.hex = 4'h8;
      SEG_9:     dec.hex = 4'h9;
      SEG_A_HEX: dec.hex = 4'hA;
      SEG_B_HEX: dec.hex = 4'hB;
      SEG_C_HEX: dec.hex = 4'hC;
      SEG_D_HEX: dec.hex = 4'hD;
      SEG_E_HEX: dec.hex = 4'hE;
      SEG_F_HEX: dec.hex = 4'hF;
      default:   dec.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_decoder.sv
// Debounced 7-segment to hex decoder with a one-entry pending slot behind the output.
// Optional build macro: SEVENSEG_DEC_BLANK_EN (all-off pattern settles silently).
module sevenseg_decoder
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         seg_in,
  sevenseg_decoder_if.master dec_bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_AT = CW'(STABLE_CYCLES - 1);

  logic [6:0]    seg_q, seg_d;
  logic [6:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          settle;
  logic          emit;
  seg_dec_t      evt_dec;

  seg_dec_t      out_q, out_d;
  logic          out_valid_q, out_valid_d;
  seg_dec_t      pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          overrun_q, overrun_d;
  logic          xfer;

  // With a single required sample the settle coincides with the candidate load.
  always_comb begin
    seg_d  = seg_in;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    settle = 1'b0;
    if (seg_q != cand_q) begin
      cand_d = seg_q;
      cnt_d  = CW'(1);
      settle = (STABLE_CYCLES == 1);
    end else begin
      if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      settle = (STABLE_CYCLES != 1) && (cnt_q == SETTLE_AT);
    end
  end

  sevenseg_lut u_lut (
    .seg (cand_d),
    .dec (evt_dec)
  );

`ifdef SEVENSEG_DEC_BLANK_EN
  assign emit = settle && (cand_d != SEG_BLANK);
`else
  assign emit = settle;
`endif

  assign xfer = out_valid_q & dec_bus.out_ready;

  // Pending is only ever full while the output is full, so draining promotes it.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overrun_d    = 1'b0;
    if (xfer) begin
      out_d        = pend_q;
      out_valid_d  = pend_valid_q;
      pend_valid_d = 1'b0;
    end
    if (emit) begin
      if (!out_valid_q || xfer) begin
        if (pend_valid_q) begin
          pend_d       = evt_dec;
          pend_valid_d = 1'b1;
        end else begin
          out_d       = evt_dec;
          out_valid_d = 1'b1;
        end
      end else begin
        pend_d       = evt_dec;
        pend_valid_d = 1'b1;
        overrun_d    = pend_valid_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dec_bus.out_valid = out_valid_q;
  assign dec_bus.out_hex   = out_q.hex;
  assign dec_bus.out_err   = out_q.err;
  assign dec_bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Randomized + directed bench for sevenseg_decoder against a run-length / two-deep queue model.
module tb_sevenseg_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_drv;
  logic       rdy;

  int checks   = 0;
  int failures = 0;

  sevenseg_decoder_if dec_if ();
  assign dec_if.out_ready = rdy;

  sevenseg_decoder #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_drv),
    .dec_bus (dec_if)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Model state: sampled-pattern history and the deliverable digits {err,hex}.
  logic [6:0] hist [$];
  logic [4:0] mq [$];
  logic [6:0] seg_q_m;
  logic       exp_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == p) return {1'b0, 4'(i)};
    return 5'b10000;
  endfunction

  function automatic bit is_blank_silent(input logic [6:0] p);
`ifdef SEVENSEG_DEC_BLANK_EN
    return (p == 7'b0000000);
`else
    return 1'b0;
`endif
  endfunction

  // A run has settled when the last S samples agree and the one before them did not.
  function automatic bit settled_now();
    int n;
    n = hist.size();
    if (n < S) return 1'b0;
    for (int k = 1; k < S; k++)
      if (hist[n-1-k] != hist[n-1]) return 1'b0;
    if (n > S && hist[n-1-S] == hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    mq.delete();
    seg_q_m = 7'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic tick();
    bit         xfer;
    logic [4:0] item;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      xfer    = (mq.size() > 0) && rdy;
      exp_ovr = 1'b0;
      hist.push_back(seg_q_m);
      if (hist.size() > S + 1) void'(hist.pop_front());
      if (xfer) begin
        item = mq.pop_front();
        $display("xfer hex=%h err=%b t=%0t", item[3:0], item[4], $time);
      end
      if (settled_now() && !is_blank_silent(hist[hist.size()-1])) begin
        item = ref_decode(hist[hist.size()-1]);
        if (mq.size() < 2) mq.push_back(item);
        else begin
          mq[1]   = item;
          exp_ovr = 1'b1;
        end
      end
      seg_q_m = seg_drv;
    end
    #1;
    chk("valid", dec_if.out_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      chk("hex", dec_if.out_hex, mq[0][3:0]);
      chk("err", dec_if.out_err, mq[0][4]);
    end
    chk("overrun", dec_if.overrun, exp_ovr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int n_valid;
  int n_ovr;
  logic [3:0] last_hex;

  initial begin
    rst     = 1'b1;
    seg_drv = 7'b0;
    rdy     = 1'b0;
    model_reset();
    do_reset();
    chk("rst_valid", dec_if.out_valid, 0);
    chk("rst_hex", dec_if.out_hex, 0);
    chk("rst_err", dec_if.out_err, 0);
    chk("rst_ovr", dec_if.overrun, 0);

    // 1: settle "2" with S+1 edges latency, delivered once
    rdy = 1'b1;
    seg_drv = 7'b1101101;
    repeat (S) tick();
    chk("t1_early", dec_if.out_valid, 0);
    tick();
    chk("t1_valid", dec_if.out_valid, 1);
    chk("t1_hex", dec_if.out_hex, 4'h2);
    chk("t1_err", dec_if.out_err, 0);
    n_valid = 0;
    repeat (8) begin tick(); if (dec_if.out_valid) n_valid++; end
    chk("t1_once", n_valid, 0);

    // 2: short run of "A" rejected, then a single "1"
    seg_drv = 7'b1110111;
    n_valid = 0;
    repeat (3) begin tick(); if (dec_if.out_valid) n_valid++; end
    seg_drv = 7'b0110000;
    repeat (10) begin
      tick();
      if (dec_if.out_valid) begin n_valid++; last_hex = dec_if.out_hex; end
    end
    chk("t2_count", n_valid, 1);
    chk("t2_hex", last_hex, 4'h1);

    // 3: stalled consumer, pending slot, overrun, back-to-back drain
    rdy = 1'b0;
    seg_drv = 7'b1111110; repeat (6) tick();
    seg_drv = 7'b0111101; repeat (6) tick();
    chk("t3_hold_valid", dec_if.out_valid, 1);
    chk("t3_hold_hex", dec_if.out_hex, 4'h0);
    n_ovr = 0;
    seg_drv = 7'b1001110;
    repeat (6) begin tick(); if (dec_if.overrun) n_ovr++; end
    chk("t3_ovr_count", n_ovr, 1);
    chk("t3_still_hex0", dec_if.out_hex, 4'h0);
    rdy = 1'b1;
    tick();
    chk("t3_second_valid", dec_if.out_valid, 1);
    chk("t3_second_hex", dec_if.out_hex, 4'hC);
    tick();
    chk("t3_drained", dec_if.out_valid, 0);

    // 4: illegal pattern
    seg_drv = 7'b1010101;
    repeat (S + 1) tick();
    chk("t4_valid", dec_if.out_valid, 1);
    chk("t4_err", dec_if.out_err, 1);
    chk("t4_hex", dec_if.out_hex, 4'h0);

    // 5: blank pattern
    seg_drv = 7'b0000000;
    n_valid = 0;
    repeat (20) begin tick(); if (dec_if.out_valid && dec_if.out_err) n_valid++; end
`ifdef SEVENSEG_DEC_BLANK_EN
    chk("t5_blank_silent", n_valid, 0);
`else
    chk("t5_blank_err", n_valid, 1);
`endif

    // 6: reset with output and pending both full
    rdy = 1'b0;
    seg_drv = 7'b1110111; repeat (6) tick();
    seg_drv = 7'b0011111; repeat (6) tick();
    do_reset();
    chk("t6_valid", dec_if.out_valid, 0);
    chk("t6_ovr", dec_if.overrun, 0);
    seg_drv = 7'b1111111;
    repeat (S + 1) tick();
    chk("t6_valid8", dec_if.out_valid, 1);
    chk("t6_hex8", dec_if.out_hex, 4'h8);
    rdy = 1'b1;
    tick();

    // Randomized runs of mixed lengths, patterns and consumer stalls
    for (int it = 0; it < 300; it++) begin
      int sel;
      int len;
      sel = $urandom_range(0, 9);
      if (sel < 7)       seg_drv = seg_tab[$urandom_range(0, 15)];
      else if (sel == 7) seg_drv = 7'b0000000;
      else               seg_drv = 7'($urandom);
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 199) == 0) do_reset();
        else tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
